// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full adder, LSB first, one bit per clock.
// IDLE accepts operands on start, RUN takes WIDTH cycles, DONE pulses for one cycle.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic             fa_sum_s;
    logic             fa_carry_s;
    logic             last_bit_s;

    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    assign fa_sum_s   = fa_sum(a_r[0], b_r[0], carry_r);
    assign fa_carry_s = fa_carry(a_r[0], b_r[0], carry_r);
    assign last_bit_s = (cnt_r == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_bit_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode; state is registered so these are glitch-free
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_r)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath: operand capture, serial shift and carry update
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        cnt_r   <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    a_r     <= a_r >> 1;
                    b_r     <= b_r >> 1;
                    // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at the LSB
                    res_r   <= {fa_sum_s, res_r[WIDTH-1:1]};
                    carry_r <= fa_carry_s;
                    cnt_r   <= cnt_r + CW'(1);
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign sum  = res_r;
    assign cout = carry_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8: reset, known sums, sweep,
// ignored restart, mid-run reset and back-to-back operation.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction; glitch_at >= 0 pulses start with other operands mid-run
    task automatic run_add(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                           input int glitch_at, input string tag);
        int          e;
        int          busy_n;
        logic [31:0] ev;
        e  = int'(ia) + int'(ib) + int'(ic);
        ev = e;
        @(negedge clk);
        start = 1'b1; a = ia; b = ib; cin = ic;
        @(negedge clk);
        start = 1'b0; a = ~ia; b = ~ib; cin = ~ic;
        busy_n = 0;
        for (int i = 0; i < W; i++) begin
            if (busy === 1'b1) busy_n++;
            check({tag, "_nodone"}, {31'd0, done}, 32'd0);
            if (i == glitch_at) begin
                start = 1'b1; a = 8'h11; b = 8'h22;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_busycycles"}, busy_n, W);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_sum"}, {24'd0, sum}, {24'd0, ev[7:0]});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ev[8]});
        @(negedge clk);
        check({tag, "_done_low"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
        check({tag, "_sum_hold"}, {24'd0, sum}, {24'd0, ev[7:0]});
        check({tag, "_cout_hold"}, {31'd0, cout}, {31'd0, ev[8]});
    endtask

    initial begin
        logic [W-1:0] vals [8];
        int           last;
        int           pulses;
        vals = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF, 8'h55, 8'hAA};

        // Reset, with start asserted alongside to show reset wins
        reset = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'h01;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        start = 1'b0; reset = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Directed vectors
        run_add(8'h00, 8'h00, 1'b0, -1, "zero");
        run_add(8'hFF, 8'h01, 1'b0, -1, "wrap");
        run_add(8'hA5, 8'h5A, 1'b1, -1, "a5_5a");
        run_add(8'h3C, 8'h0F, 1'b0, -1, "3c_0f");
        run_add(8'hFF, 8'hFF, 1'b1, -1, "max");

        // Start during RUN with different operands must be ignored
        run_add(8'h3C, 8'h0F, 1'b0, 2, "ignore");

        // Corner-value sweep
        for (int ai = 0; ai < 8; ai++)
            for (int bi = 0; bi < 8; bi++)
                for (int c = 0; c < 2; c++)
                    run_add(vals[ai], vals[bi], 1'(c), -1, "sweep");

        // Random operands
        for (int r = 0; r < 40; r++)
            run_add(8'($urandom), 8'($urandom), 1'($urandom), -1, "rand");

        // Reset while RUN is about to process bit 4
        @(negedge clk);
        start = 1'b1; a = 8'h3C; b = 8'h0F; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_sum", {24'd0, sum}, 32'd0);
        check("midrst_cout", {31'd0, cout}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("midrst_nodone", {31'd0, done}, 32'd0);
        end
        run_add(8'h3C, 8'h0F, 1'b0, -1, "after_rst");

        // Start held high: one result every W+2 cycles
        @(negedge clk);
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        last = -1; pulses = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            check("hold_exclusive", {31'd0, busy & done}, 32'd0);
            if (done === 1'b1) begin
                pulses++;
                check("hold_sum", {24'd0, sum}, 32'h46);
                check("hold_cout", {31'd0, cout}, 32'd0);
                if (last >= 0) check("hold_spacing", cyc - last, W + 2);
                last = cyc;
            end
        end
        start = 1'b0;
        check("hold_pulses", pulses, 3);
        repeat (12) @(negedge clk);
        check("final_idle", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
